// File: rtl/ram_ser_pkg.sv
// ram_ser_pkg: shared constants and the FSM state encoding for the RAM
// serializer controller.
//   NBITS_WORD : data word width
//   NWORDS     : RAM depth
//   ADDR_W     : RAM address width
//   CNT_W      : width of a word count able to hold 0..NWORDS
//   state_e    : controller state, encoding is visible on state_dbg
package ram_ser_pkg;

  localparam int unsigned NBITS_WORD = 4;
  localparam int unsigned NWORDS     = 4;
  localparam int unsigned ADDR_W     = $clog2(NWORDS);
  localparam int unsigned CNT_W      = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_reg4.sv
// shift_reg4: 4-bit parallel-load, right-shift register, zero fill at MSB.
// Ports:
//   clk_2  : clock, rising edge
//   reset  : asynchronous, active-high clear
//   load   : load din (takes priority over shift)
//   shift  : shift right by one, MSB <- 0
//   din    : parallel load data
//   sout   : current LSB (registered)
module shift_reg4 (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] din,
  output logic       sout
);

  logic [3:0] shreg_q;
  logic [3:0] shreg_d;

  // Next-state: load wins over shift
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {1'b0, shreg_q[3:1]};
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout = shreg_q[0];

endmodule

// File: rtl/ram_serializer_ctrl.sv
// ram_serializer_ctrl: small host-writable RAM whose words are sent out
// LSB first as a serial bit stream, one block of consecutive words per
// start request.
// Ports:
//   clk_2, reset        : clock (rising edge), async active-high reset
//   wr_en/wr_addr/wr_data : host RAM write, honoured only in IDLE or DONE
//   start/start_addr/word_count : block request, sampled only in IDLE
//   serial_out/serial_valid     : serial data bit and its qualifier
//   busy                : high whenever the FSM is not in IDLE
//   done                : one-cycle block completion pulse
//   cur_addr            : RAM address currently being serialized
//   state_dbg           : encoded FSM state
module ram_serializer_ctrl #(
  parameter  int unsigned NBITS_WORD = ram_ser_pkg::NBITS_WORD,
  parameter  int unsigned NWORDS     = ram_ser_pkg::NWORDS,
  localparam int unsigned AW         = $clog2(NWORDS),
  localparam int unsigned CW         = $clog2(NWORDS + 1)
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [NBITS_WORD-1:0] wr_data,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [CW-1:0]         word_count,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         cur_addr,
  output logic [1:0]            state_dbg
);

  import ram_ser_pkg::*;

  localparam int unsigned BW = (NBITS_WORD > 1) ? $clog2(NBITS_WORD) : 1;

  state_e                state_q,    state_d;
  logic [AW-1:0]         cur_addr_q, cur_addr_d;
  logic [CW-1:0]         rem_q,      rem_d;
  logic [BW-1:0]         bit_cnt_q,  bit_cnt_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  valid_q,    valid_d;
  logic [NBITS_WORD-1:0] ram_q [NWORDS];
  logic [NBITS_WORD-1:0] ram_d [NWORDS];

  logic                  ram_we;
  logic [NBITS_WORD-1:0] rd_word;
  logic                  sh_load;
  logic                  sh_shift;

  // RAM write path: blocked while a block is being read/shifted
  always_comb begin
    ram_we = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    ram_d  = ram_q;
    if (ram_we) begin
      ram_d[wr_addr] = wr_data;
    end
  end

  // Combinational read; a write on the start edge is visible in READ
  assign rd_word = ram_q[cur_addr_q];

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    bit_cnt_d  = bit_cnt_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            cur_addr_d = start_addr;
            rem_d      = word_count;
            state_d    = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_READ: begin
        sh_load   = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        sh_shift = 1'b1;
        if (bit_cnt_q == BW'(NBITS_WORD - 1)) begin
          bit_cnt_d = '0;
          if (rem_q > CW'(1)) begin
            rem_d      = rem_q - CW'(1);
            cur_addr_d = (cur_addr_q == AW'(NWORDS - 1)) ? '0
                                                         : cur_addr_q + AW'(1);
            state_d    = ST_READ;
          end else begin
            rem_d   = '0;
            state_d = ST_DONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    valid_d = (state_d == ST_SHIFT);
  end

  // Controller and RAM registers
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      ram_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      ram_q      <= ram_d;
    end
  end

  // The register is loaded only on entry to SHIFT and is shifted empty by
  // the last SHIFT cycle, so its LSB is already 0 outside SHIFT.
  shift_reg4 u_shreg (
    .clk_2 (clk_2),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (rd_word),
    .sout  (serial_out)
  );

  assign serial_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_addr     = cur_addr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ram_serializer_ctrl.sv
// Directed bench for ram_serializer_ctrl: table of block requests against
// a known RAM image, plus hand-written multi-cycle corner sequences.
module tb_ram_serializer_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic [1:0] start_addr;
  logic [2:0] word_count;
  logic       serial_out;
  logic       serial_valid;
  logic       busy;
  logic       done;
  logic [1:0] cur_addr;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  ram_serializer_ctrl dut (
    .clk_2        (clk_2),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .start_addr   (start_addr),
    .word_count   (word_count),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done),
    .cur_addr     (cur_addr),
    .state_dbg    (state_dbg)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    string      name;
    logic [1:0] sa;
    logic [2:0] wc;
    logic [15:0] exp_bits;   // serial bits, first bit in [0]
    logic [7:0]  exp_addrs;  // cur_addr per word, first word in [1:0]
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic write_word(input logic [1:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (state_dbg == 2'd0) break;
      tick();
    end
    check({name, "_idle"}, 32'(state_dbg), 32'd0);
  endtask

  // Issue one block request and collect the serial stream up to done.
  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run_block(input string name, input logic [1:0] sa,
                           input logic [2:0] wc, input logic [15:0] eb,
                           input logic [7:0] ea);
    logic [15:0] gb;
    logic [7:0]  ga;
    int nb, dc, fv, zv;
    gb = '0; ga = '0; nb = 0; dc = -1; fv = -1; zv = 0;
    start      = 1'b1;
    start_addr = sa;
    word_count = wc;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (serial_valid === 1'b1) begin
        if (fv < 0) fv = c;
        if (nb < 16) begin
          gb[nb] = serial_out;
          if ((nb % 4) == 0) ga[2*(nb/4) +: 2] = cur_addr;
        end
        nb++;
      end else if (serial_out !== 1'b0) begin
        zv++;
      end
      if (done === 1'b1) begin
        dc = c;
        break;
      end
      tick();
    end
    check({name, "_bits"},  32'(gb), 32'(eb));
    check({name, "_addrs"}, 32'(ga), 32'(ea));
    check({name, "_nbits"}, 32'(nb), 32'(4 * int'(wc)));
    check({name, "_done_cycle"}, 32'(dc),
          (wc == 3'd0) ? 32'd1 : 32'(5 * int'(wc) + 1));
    check({name, "_first_valid"}, 32'(fv),
          (wc == 3'd0) ? 32'hFFFF_FFFF : 32'd2);
    check({name, "_out_zero_when_invalid"}, 32'(zv), 32'd0);
    tick();
    check({name, "_after_done"}, 32'({done, busy, state_dbg}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_state[8];

    vt[0] = '{"one_word_a0",   2'd0, 3'd1, 16'h0005, 8'h00};
    vt[1] = '{"two_wrap_a3",   2'd3, 3'd2, 16'h005C, 8'h03};
    vt[2] = '{"zero_count",    2'd2, 3'd0, 16'h0000, 8'h00};
    vt[3] = '{"four_from_a1",  2'd1, 3'd4, 16'h5C3A, 8'h39};
    vt[4] = '{"three_from_a2", 2'd2, 3'd3, 16'h05C3, 8'h0E};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; word_count = '0;
    #12;
    check("reset_outputs",
          32'({serial_out, serial_valid, busy, done, cur_addr, state_dbg}),
          32'd0);
    @(negedge clk_2);
    reset = 1'b0;
    tick();

    write_word(2'd0, 4'h5);
    write_word(2'd1, 4'hA);
    write_word(2'd2, 4'h3);
    write_word(2'd3, 4'hC);

    for (int i = 0; i < 5; i++) begin
      run_block(vt[i].name, vt[i].sa, vt[i].wc, vt[i].exp_bits,
                vt[i].exp_addrs);
    end

    // Write attempted during SHIFT must be dropped
    start = 1'b1; start_addr = 2'd0; word_count = 3'd1;
    tick();
    start = 1'b0;
    tick();
    check("shift_state_for_write", 32'(state_dbg), 32'd2);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h0;
    tick();
    wr_en = 1'b0;
    wait_idle("shift_write");
    run_block("after_shift_write", 2'd1, 3'd1, 16'h000A, 8'h01);

    // Write and start in the same IDLE cycle: READ sees the new word
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hF;
    run_block("start_with_write", 2'd1, 3'd1, 16'h000F, 8'h01);

    // start held high: next block only after a pass through IDLE
    exp_state = '{1, 2, 2, 2, 2, 3, 0, 1};
    start = 1'b1; start_addr = 2'd0; word_count = 3'd1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("held_state_c%0d", c), 32'(state_dbg),
            32'(exp_state[c-1]));
      check($sformatf("held_done_c%0d", c), 32'(done), 32'(c == 6));
      if (c == 3) check("held_addr_not_resampled", 32'(cur_addr), 32'd0);
      if (c == 8) check("held_second_pass_addr", 32'(cur_addr), 32'd2);
      if (c == 2) start_addr = 2'd2;
      if (c < 8) tick();
    end
    start = 1'b0;
    wait_idle("held_start");

    // Asynchronous reset in the second SHIFT cycle of a block
    start = 1'b1; start_addr = 2'd0; word_count = 3'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_shift", 32'({state_dbg, serial_valid}), 32'b101);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          32'({serial_out, serial_valid, busy, done, cur_addr, state_dbg}),
          32'd0);
    tick();
    @(negedge clk_2);
    reset = 1'b0;
    tick();
    check("post_reset_idle", 32'({done, busy, state_dbg}), 32'd0);
    run_block("ram_cleared", 2'd0, 3'd4, 16'h0000, 8'hE4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
